// File: rtl/warbug_input_pkg.sv
// Shared constants and types for the Warbug input conditioner.
// Scancodes are 9-bit {extended, code}; KEY_CTRL matches either extension.
package warbug_input_pkg;

    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_RIGHT = 9'h174;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [7:0] KEY_CTRL  = 8'h14;
    localparam logic [8:0] KEY_F1    = 9'h005;
    localparam logic [8:0] KEY_F2    = 9'h006;
    localparam logic [8:0] KEY_COIN  = 9'h02E;

    // Bit positions inside the CSJUDLR output words.
    localparam int unsigned BIT_R     = 0;
    localparam int unsigned BIT_L     = 1;
    localparam int unsigned BIT_D     = 2;
    localparam int unsigned BIT_U     = 3;
    localparam int unsigned BIT_FIRE  = 4;
    localparam int unsigned BIT_START = 5;
    localparam int unsigned BIT_COIN  = 6;

    // Bit positions inside the MiSTer joystick words (also used for the key register).
    localparam int unsigned JOY_R      = 0;
    localparam int unsigned JOY_L      = 1;
    localparam int unsigned JOY_D      = 2;
    localparam int unsigned JOY_U      = 3;
    localparam int unsigned JOY_FIRE   = 4;
    localparam int unsigned JOY_START1 = 5;
    localparam int unsigned JOY_START2 = 6;
    localparam int unsigned JOY_COIN   = 7;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

endpackage

// File: rtl/coin_pulser.sv
// Coin request queue plus pulse/gap timer: each queued request becomes one
// COIN_PULSE-cycle pulse followed by at least COIN_GAP low cycles.
module coin_pulser
    import warbug_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 600000,
    parameter int unsigned COIN_GAP   = 1200000,
    parameter int unsigned COIN_QMAX  = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    output logic pulse_o,
    output logic busy_o
);

    localparam int unsigned TMax = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;
    localparam int unsigned QW   = $clog2(COIN_QMAX + 1);

    coin_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [QW-1:0] queue_q, queue_d;
    logic          deq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            timer_q <= '0;
            queue_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            queue_q <= queue_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        deq     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (queue_q != '0) begin
                    state_d = PULSE;
                    timer_d = TW'(COIN_PULSE - 1);
                    deq     = 1'b1;
                end
            end
            PULSE: begin
                if (timer_q == '0) begin
                    state_d = GAP;
                    timer_d = TW'(COIN_GAP - 1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous request and dequeue cancel out.
    always_comb begin
        queue_d = queue_q;
        if (req_i && !deq) begin
            if (queue_q != QW'(COIN_QMAX)) begin
                queue_d = queue_q + QW'(1);
            end
        end else if (!req_i && deq) begin
            queue_d = queue_q - QW'(1);
        end
    end

    assign pulse_o = (state_q == PULSE);
    assign busy_o  = (state_q != IDLE) || (queue_q != '0);

endmodule

// File: rtl/warbug_input_ctrl.sv
// Input conditioner: PS/2 and joystick decode, merge, optional rotation remap,
// coin pulse generation and the registered CSJUDLR words for the core.
module warbug_input_ctrl
    import warbug_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 600000,
    parameter int unsigned COIN_GAP   = 1200000,
    parameter int unsigned COIN_QMAX  = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    input  logic        auto_coin,
    output logic [6:0]  p1_csjudlr,
    output logic [6:0]  p2_csjudlr,
    output logic        coin_busy
);

    logic       toggle_q;
    logic [7:0] key_q, key_d;
    logic [7:0] merged;
    logic       coin_prev_q, start1_prev_q, start2_prev_q;
    logic       key_event, key_pressed;
    logic [8:0] key_code;
    logic       coin_req, coin_pulse, pulser_busy;
    logic       up, down, left, right;
    logic [6:0] p1_q, p1_d, p2_q, p2_d;
    logic       busy_q;
    logic       unused_joy_hi;

    assign unused_joy_hi = ^{joystick_0[15:8], joystick_1[15:8]};

    assign key_event   = ps2_key[10] ^ toggle_q;
    assign key_pressed = ps2_key[9];
    assign key_code    = ps2_key[8:0];

    // Key register shares the joystick bit layout so merging is a plain OR.
    always_comb begin
        key_d = key_q;
        if (key_event) begin
            if (key_code == KEY_UP) begin
                key_d[JOY_U] = key_pressed;
            end else if (key_code == KEY_DOWN) begin
                key_d[JOY_D] = key_pressed;
            end else if (key_code == KEY_LEFT) begin
                key_d[JOY_L] = key_pressed;
            end else if (key_code == KEY_RIGHT) begin
                key_d[JOY_R] = key_pressed;
            end else if (key_code == KEY_SPACE || key_code[7:0] == KEY_CTRL) begin
                key_d[JOY_FIRE] = key_pressed;
            end else if (key_code == KEY_F1) begin
                key_d[JOY_START1] = key_pressed;
            end else if (key_code == KEY_F2) begin
                key_d[JOY_START2] = key_pressed;
            end else if (key_code == KEY_COIN) begin
                key_d[JOY_COIN] = key_pressed;
            end
        end
    end

    assign merged = key_q | joystick_0[7:0] | joystick_1[7:0];

    assign coin_req = (merged[JOY_COIN] && !coin_prev_q) ||
                      (auto_coin && ((merged[JOY_START1] && !start1_prev_q) ||
                                     (merged[JOY_START2] && !start2_prev_q)));

    coin_pulser #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP),
        .COIN_QMAX  (COIN_QMAX)
    ) u_coin_pulser (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .req_i   (coin_req),
        .pulse_o (coin_pulse),
        .busy_o  (pulser_busy)
    );

    // Horizontal cabinet: stick directions rotate a quarter turn.
    always_comb begin
        if (rotate) begin
            up    = merged[JOY_L];
            down  = merged[JOY_R];
            left  = merged[JOY_D];
            right = merged[JOY_U];
        end else begin
            up    = merged[JOY_U];
            down  = merged[JOY_D];
            left  = merged[JOY_L];
            right = merged[JOY_R];
        end
    end

    always_comb begin
        p1_d = '0;
        p1_d[BIT_R]     = right;
        p1_d[BIT_L]     = left;
        p1_d[BIT_D]     = down;
        p1_d[BIT_U]     = up;
        p1_d[BIT_FIRE]  = merged[JOY_FIRE];
        p1_d[BIT_START] = merged[JOY_START1];
        p1_d[BIT_COIN]  = coin_pulse;
        p2_d = p1_d;
        p2_d[BIT_START] = merged[JOY_START2];
        p2_d[BIT_COIN]  = 1'b0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q      <= 1'b0;
            key_q         <= '0;
            coin_prev_q   <= 1'b0;
            start1_prev_q <= 1'b0;
            start2_prev_q <= 1'b0;
            p1_q          <= '0;
            p2_q          <= '0;
            busy_q        <= 1'b0;
        end else begin
            toggle_q      <= ps2_key[10];
            key_q         <= key_d;
            coin_prev_q   <= merged[JOY_COIN];
            start1_prev_q <= merged[JOY_START1];
            start2_prev_q <= merged[JOY_START2];
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            busy_q        <= pulser_busy;
        end
    end

    assign p1_csjudlr = p1_q;
    assign p2_csjudlr = p2_q;
    assign coin_busy  = busy_q;

endmodule

// File: tb/tb_warbug_input_ctrl.sv
// Bench for warbug_input_ctrl: vector table, directed corner sequences and a
// randomized run against a timeline-based reference model.
module tb_warbug_input_ctrl;

    localparam int P = 4;
    localparam int G = 6;
    localparam int Q = 3;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;
    logic        rotate = 1'b0;
    logic        auto_coin = 1'b0;
    logic [6:0]  p1_csjudlr, p2_csjudlr;
    logic        coin_busy;

    warbug_input_ctrl #(
        .COIN_PULSE (P),
        .COIN_GAP   (G),
        .COIN_QMAX  (Q)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .rotate     (rotate),
        .auto_coin  (auto_coin),
        .p1_csjudlr (p1_csjudlr),
        .p2_csjudlr (p2_csjudlr),
        .coin_busy  (coin_busy)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad = 0;

    // Reference model: held keys, request history and a pulse timeline.
    int   ek = 0;
    int   last_d = -1000;
    int   pend = 0;
    bit   tog, pc, ps1, ps2p;
    bit   h_u, h_d, h_l, h_r, h_f, h_s1, h_s2, h_c;
    logic [6:0] m_p1 = '0;
    logic [6:0] m_p2 = '0;
    logic       m_busy = 1'b0;

    function automatic bit in_pulse(input int j);
        return (j >= last_d) && (j <= last_d + P - 1);
    endfunction

    function automatic bit active(input int j);
        return (j >= last_d) && (j <= last_d + P + G - 1);
    endfunction

    task automatic model_reset();
        last_d = -1000; pend = 0;
        tog = 0; pc = 0; ps1 = 0; ps2p = 0;
        h_u = 0; h_d = 0; h_l = 0; h_r = 0; h_f = 0; h_s1 = 0; h_s2 = 0; h_c = 0;
        m_p1 = '0; m_p2 = '0; m_busy = 1'b0;
    endtask

    task automatic model_edge();
        bit mu, md, ml, mr, mf, ms1, ms2, mc, ru, rd, rl, rr, req, deq;
        logic [8:0] code;
        mr  = h_r  | joystick_0[0] | joystick_1[0];
        ml  = h_l  | joystick_0[1] | joystick_1[1];
        md  = h_d  | joystick_0[2] | joystick_1[2];
        mu  = h_u  | joystick_0[3] | joystick_1[3];
        mf  = h_f  | joystick_0[4] | joystick_1[4];
        ms1 = h_s1 | joystick_0[5] | joystick_1[5];
        ms2 = h_s2 | joystick_0[6] | joystick_1[6];
        mc  = h_c  | joystick_0[7] | joystick_1[7];
        if (rotate) begin
            ru = ml; rd = mr; rl = md; rr = mu;
        end else begin
            ru = mu; rd = md; rl = ml; rr = mr;
        end
        m_p1   = {in_pulse(ek - 1), ms1, mf, ru, rd, rl, rr};
        m_p2   = {1'b0, ms2, mf, ru, rd, rl, rr};
        m_busy = (pend > 0) || active(ek - 1);
        req = (mc && !pc) || (auto_coin && ((ms1 && !ps1) || (ms2 && !ps2p)));
        deq = !active(ek - 1) && (pend > 0);
        if (deq) last_d = ek;
        if (req && !deq) pend = (pend < Q) ? pend + 1 : Q;
        else if (!req && deq) pend = pend - 1;
        pc = mc; ps1 = ms1; ps2p = ms2;
        if (ps2_key[10] != tog) begin
            code = ps2_key[8:0];
            case (code)
                9'h175: h_u = ps2_key[9];
                9'h172: h_d = ps2_key[9];
                9'h16B: h_l = ps2_key[9];
                9'h174: h_r = ps2_key[9];
                9'h005: h_s1 = ps2_key[9];
                9'h006: h_s2 = ps2_key[9];
                9'h02E: h_c = ps2_key[9];
                default: if (code == 9'h029 || code[7:0] == 8'h14) h_f = ps2_key[9];
            endcase
        end
        tog = ps2_key[10];
        ek++;
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_edge();
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_key(input bit pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    typedef struct {
        logic [15:0] j0;
        logic [15:0] j1;
        logic        rot;
        logic [6:0]  p1;
        logic [6:0]  p2;
    } vec_t;

    vec_t tbl[14];
    logic [8:0] codes[12];

    initial begin
        int coin_h[24], busy_h[24], s1_h[24];
        int first, cnt, last, bfall, rises, low_run, min_gap, seen;
        bit prev;

        tbl[0]  = '{16'h0001, 16'h0000, 1'b0, 7'h01, 7'h01};
        tbl[1]  = '{16'h0002, 16'h0000, 1'b0, 7'h02, 7'h02};
        tbl[2]  = '{16'h0004, 16'h0000, 1'b0, 7'h04, 7'h04};
        tbl[3]  = '{16'h0008, 16'h0000, 1'b0, 7'h08, 7'h08};
        tbl[4]  = '{16'h0010, 16'h0000, 1'b0, 7'h10, 7'h10};
        tbl[5]  = '{16'h0020, 16'h0000, 1'b0, 7'h20, 7'h00};
        tbl[6]  = '{16'h0000, 16'h0040, 1'b0, 7'h00, 7'h20};
        tbl[7]  = '{16'h0002, 16'h0000, 1'b1, 7'h08, 7'h08};
        tbl[8]  = '{16'h0000, 16'h0001, 1'b1, 7'h04, 7'h04};
        tbl[9]  = '{16'h0004, 16'h0000, 1'b1, 7'h02, 7'h02};
        tbl[10] = '{16'h0008, 16'h0000, 1'b1, 7'h01, 7'h01};
        tbl[11] = '{16'h0011, 16'h0002, 1'b1, 7'h1C, 7'h1C};
        tbl[12] = '{16'hFF00, 16'h0000, 1'b0, 7'h00, 7'h00};
        tbl[13] = '{16'h0060, 16'h0001, 1'b0, 7'h21, 7'h21};

        codes = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h075, 9'h029,
                  9'h014, 9'h114, 9'h005, 9'h006, 9'h02E, 9'h01C};

        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        check("reset_p1", 32'(p1_csjudlr), 32'h0);
        check("reset_p2", 32'(p2_csjudlr), 32'h0);
        check("reset_busy", 32'(coin_busy), 32'h0);
        reset_n = 1'b1;
        step();
        check("idle_p1", 32'(p1_csjudlr), 32'h0);
        check("idle_busy", 32'(coin_busy), 32'h0);

        for (int i = 0; i < 14; i++) begin
            joystick_0 = tbl[i].j0;
            joystick_1 = tbl[i].j1;
            rotate     = tbl[i].rot;
            step();
            check($sformatf("vec%0d_p1", i), 32'(p1_csjudlr), 32'(tbl[i].p1));
            check($sformatf("vec%0d_p2", i), 32'(p2_csjudlr), 32'(tbl[i].p2));
        end
        joystick_0 = '0; joystick_1 = '0; rotate = 1'b0;
        step();

        // Extended up key: two-cycle latency on press and release.
        send_key(1'b1, 9'h175);
        step();
        check("up_press_lat1", 32'(p1_csjudlr[3]), 32'h0);
        step();
        check("up_press_lat2", 32'(p1_csjudlr[3]), 32'h1);
        send_key(1'b0, 9'h175);
        step();
        check("up_rel_lat1", 32'(p1_csjudlr[3]), 32'h1);
        step();
        check("up_rel_lat2", 32'(p1_csjudlr[3]), 32'h0);

        rotate = 1'b1;
        send_key(1'b1, 9'h175);
        step(); step();
        check("up_rotated", 32'(p1_csjudlr), 32'h01);
        send_key(1'b0, 9'h175);
        step(); step();
        rotate = 1'b0;
        check("up_rot_rel", 32'(p1_csjudlr), 32'h00);

        send_key(1'b1, 9'h075);
        step(); step();
        check("non_ext_ignored", 32'(p1_csjudlr), 32'h00);
        send_key(1'b0, 9'h075);
        step(); step();

        // Auto-coin from F1.
        auto_coin = 1'b1;
        send_key(1'b1, 9'h005);
        for (int i = 0; i < 24; i++) begin
            step();
            coin_h[i] = int'(p1_csjudlr[6]);
            busy_h[i] = int'(coin_busy);
            s1_h[i]   = int'(p1_csjudlr[5]);
        end
        first = -1; cnt = 0; last = -1; bfall = -1;
        for (int i = 0; i < 24; i++) begin
            if (coin_h[i] == 1) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        for (int i = 0; i < 24; i++)
            if (bfall < 0 && last >= 0 && i > last && busy_h[i] == 0) bfall = i;
        check("f1_start1_lat1", 32'(s1_h[0]), 32'h0);
        check("f1_start1_lat2", 32'(s1_h[1]), 32'h1);
        check("f1_coin_first", 32'(first), 32'd3);
        check("f1_coin_count", 32'(cnt), 32'd4);
        check("f1_coin_last", 32'(last), 32'd6);
        check("f1_busy_early", 32'(busy_h[2]), 32'h1);
        check("f1_busy_fall", 32'(bfall - (last + 1)), 32'd6);
        send_key(1'b0, 9'h005);
        auto_coin = 1'b0;
        repeat (4) step();

        // Five coin edges against a queue of three.
        rises = 0; low_run = 0; min_gap = 1000; prev = 0;
        for (int i = 0; i < 90; i++) begin
            if (i < 10) joystick_0[7] = (i % 2 == 0);
            else joystick_0[7] = 1'b0;
            step();
            if (p1_csjudlr[6] && !prev) begin
                rises++;
                if (rises > 1 && low_run < min_gap) min_gap = low_run;
                low_run = 0;
            end else if (!p1_csjudlr[6]) begin
                low_run++;
            end
            prev = p1_csjudlr[6];
        end
        check("qsat_pulses", 32'(rises), 32'd4);
        check("qsat_min_gap", 32'(min_gap >= G), 32'h1);
        check("qsat_busy_end", 32'(coin_busy), 32'h0);

        // Reset in the middle of a pulse with more requests queued.
        joystick_0[7] = 1'b1; step();
        joystick_0[7] = 1'b0; step();
        joystick_0[7] = 1'b1; step();
        joystick_0[7] = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (p1_csjudlr[6]) seen = 1;
        end
        check("rst_pulse_seen", 32'(seen), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_p1", 32'(p1_csjudlr), 32'h0);
        check("rst_async_busy", 32'(coin_busy), 32'h0);
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (p1_csjudlr[6]) cnt++;
        end
        check("rst_no_pulses", 32'(cnt), 32'd0);
        check("rst_busy_after", 32'(coin_busy), 32'h0);

        // Randomized run against the reference model.
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 15) == 0) joystick_0[b] = ~joystick_0[b];
                if ($urandom_range(0, 15) == 0) joystick_1[b] = ~joystick_1[b];
            end
            if ($urandom_range(0, 31) == 0) joystick_1[15:8] = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                send_key(1'($urandom_range(0, 1)), codes[$urandom_range(0, 11)]);
            if ($urandom_range(0, 39) == 0) rotate = ~rotate;
            if ($urandom_range(0, 49) == 0) auto_coin = ~auto_coin;
            step();
            check("rand_p1", 32'(p1_csjudlr), 32'(m_p1));
            check("rand_p2", 32'(p2_csjudlr), 32'(m_p2));
            check("rand_busy", 32'(coin_busy), 32'(m_busy));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
